// File: rtl/uart_pkg.sv
// Shared definitions for the UART interrupt controller: source indices,
// fixed service priority and FSM state type (HOLDOFF exists only with UART_IRQ_HOLDOFF_EN).
package uart_pkg;

   localparam logic [1:0] IRQ_RX_EMPTY = 2'd0;
   localparam logic [1:0] IRQ_RX_FULL  = 2'd1;
   localparam logic [1:0] IRQ_TX_EMPTY = 2'd2;
   localparam logic [1:0] IRQ_TX_FULL  = 2'd3;

   // Element 0 is served first.
   localparam logic [1:0] PRIO_ORDER [4] = '{IRQ_RX_FULL, IRQ_TX_FULL, IRQ_TX_EMPTY, IRQ_RX_EMPTY};

`ifdef UART_IRQ_HOLDOFF_EN
   typedef enum logic [1:0] {IDLE = 2'd0, ACTIVE = 2'd1, HOLDOFF = 2'd2} irq_state_t;
`else
   typedef enum logic [1:0] {IDLE = 2'd0, ACTIVE = 2'd1} irq_state_t;
`endif

endpackage

// File: rtl/uart_irq_prio.sv
// Fixed-priority selector: picks the highest-priority asserted request
// according to uart_pkg::PRIO_ORDER.
module uart_irq_prio
   import uart_pkg::*;
(
   input  logic [3:0] req,
   output logic [1:0] id,
   output logic       valid
);

   // Walk from lowest to highest priority so the last match wins.
   always_comb begin
      id    = 2'd0;
      valid = |req;
      for (int i = 3; i >= 0; i--) begin
         if (req[PRIO_ORDER[i]]) id = PRIO_ORDER[i];
      end
   end

endmodule

// File: rtl/uart_irq_ctrl.sv
// UART interrupt controller: edge-detects FIFO flags into sticky pending bits and
// signals one source at a time. Define UART_IRQ_HOLDOFF_EN for a post-ack holdoff.
module uart_irq_ctrl
   import uart_pkg::*;
#(
   parameter int HOLDOFF_CYCLES = 16
)
(
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] status,
   input  logic [3:0] en_mask,
   input  logic       clr_valid,
   input  logic [3:0] clr_mask,
   input  logic       ack,
   output logic [3:0] pending,
   output logic       irq,
   output logic [1:0] irq_id,
   output logic [7:0] irq_count
);

   if (HOLDOFF_CYCLES < 1) begin : g_bad_holdoff
      $error("HOLDOFF_CYCLES must be at least 1");
   end

   irq_state_t state;
   logic [3:0] status_q;
   logic [3:0] rise;
   logic [3:0] set_bits;
   logic [3:0] clr_bits;
   logic [3:0] qualified;
   logic [1:0] sel_id;
   logic       sel_valid;
   logic       ack_take;

`ifdef UART_IRQ_HOLDOFF_EN
   localparam int CNT_W = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;
   logic [CNT_W-1:0] holdoff_cnt;
`endif

   assign rise      = status & ~status_q;
   assign set_bits  = rise & en_mask;
   assign ack_take  = (state == ACTIVE) && ack;
   assign clr_bits  = (clr_valid ? clr_mask : 4'b0000) | (ack_take ? (4'b0001 << irq_id) : 4'b0000);
   assign qualified = pending & en_mask;

   uart_irq_prio u_prio (
      .req   (qualified),
      .id    (sel_id),
      .valid (sel_valid)
   );

   // Set is OR-ed in after the clear so a coincident set wins.
   always_ff @(posedge clk) begin
      if (rst) begin
         status_q <= 4'b0000;
         pending  <= 4'b0000;
      end else begin
         status_q <= status;
         pending  <= (pending & ~clr_bits) | set_bits;
      end
   end

   // An ack takes precedence over a source dropping in the same cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         irq       <= 1'b0;
         irq_id    <= 2'd0;
         irq_count <= 8'd0;
`ifdef UART_IRQ_HOLDOFF_EN
         holdoff_cnt <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (sel_valid) begin
                  state  <= ACTIVE;
                  irq    <= 1'b1;
                  irq_id <= sel_id;
               end
            end
            ACTIVE: begin
               if (ack) begin
                  irq <= 1'b0;
                  if (irq_count != 8'hFF) irq_count <= irq_count + 8'd1;
`ifdef UART_IRQ_HOLDOFF_EN
                  state       <= HOLDOFF;
                  holdoff_cnt <= CNT_W'(HOLDOFF_CYCLES - 1);
`else
                  state <= IDLE;
`endif
               end else if (!pending[irq_id] || !en_mask[irq_id]) begin
                  state <= IDLE;
                  irq   <= 1'b0;
               end
            end
`ifdef UART_IRQ_HOLDOFF_EN
            HOLDOFF: begin
               if (holdoff_cnt == '0) state <= IDLE;
               else holdoff_cnt <= holdoff_cnt - 1'b1;
            end
`endif
            default: begin
               state <= IDLE;
               irq   <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_irq_ctrl.sv
// Directed self-checking bench for uart_irq_ctrl; the holdoff scenario runs
// only when UART_IRQ_HOLDOFF_EN is defined.
module tb_uart_irq_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] status;
   logic [3:0] en_mask;
   logic       clr_valid;
   logic [3:0] clr_mask;
   logic       ack;
   logic [3:0] pending;
   logic       irq;
   logic [1:0] irq_id;
   logic [7:0] irq_count;

   int compared   = 0;
   int mismatched = 0;

   always #5 clk = ~clk;

   uart_irq_ctrl #(.HOLDOFF_CYCLES(16)) dut (
      .clk       (clk),
      .rst       (rst),
      .status    (status),
      .en_mask   (en_mask),
      .clr_valid (clr_valid),
      .clr_mask  (clr_mask),
      .ack       (ack),
      .pending   (pending),
      .irq       (irq),
      .irq_id    (irq_id),
      .irq_count (irq_count)
   );

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic [3:0] s, input logic [3:0] m,
                                input logic cv, input logic [3:0] cm, input logic a);
      status    = s;
      en_mask   = m;
      clr_valid = cv;
      clr_mask  = cm;
      ack       = a;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      compared++;
      if (observed !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
      end
   endtask

   // Bounded wait; callers check irq afterwards so a timeout shows as a failure.
   task automatic waitIrq(input int bound);
      int n = 0;
      while (irq !== 1'b1 && n < bound) begin
         tick(1);
         n++;
      end
   endtask

   initial begin
      rst = 1'b1;
      applyStimulus(4'h0, 4'h0, 1'b0, 4'h0, 1'b0);
      tick(2);
      checkOutput("rst_pending", 32'(pending), 32'h0);
      checkOutput("rst_irq", 32'(irq), 32'h0);
      checkOutput("rst_irq_id", 32'(irq_id), 32'h0);
      checkOutput("rst_count", 32'(irq_count), 32'h0);
      rst = 1'b0;
      applyStimulus(4'h0, 4'hF, 1'b0, 4'h0, 1'b0);
      tick(1);

      // rx_full rise, latency and ack
      applyStimulus(4'b0010, 4'hF, 1'b0, 4'h0, 1'b0);
      tick(1);
      checkOutput("rise_pending", 32'(pending), 32'b0010);
      checkOutput("latency_irq_low", 32'(irq), 32'h0);
      tick(1);
      checkOutput("latency_irq_high", 32'(irq), 32'h1);
      checkOutput("latency_irq_id", 32'(irq_id), 32'h1);
      tick(2);
      checkOutput("irq_held", 32'(irq), 32'h1);
      applyStimulus(4'b0010, 4'hF, 1'b0, 4'h0, 1'b1);
      tick(1);
      checkOutput("ack_pending", 32'(pending), 32'h0);
      checkOutput("ack_irq", 32'(irq), 32'h0);
      checkOutput("ack_count", 32'(irq_count), 32'h1);
      applyStimulus(4'h0, 4'hF, 1'b0, 4'h0, 1'b0);
      tick(1);

      // rx_empty + tx_full together: tx_full first, then rx_empty
      applyStimulus(4'b1001, 4'hF, 1'b0, 4'h0, 1'b0);
      tick(1);
      checkOutput("dual_pending", 32'(pending), 32'b1001);
      waitIrq(40);
      checkOutput("dual_irq", 32'(irq), 32'h1);
      checkOutput("dual_first_id", 32'(irq_id), 32'h3);
      applyStimulus(4'b1001, 4'hF, 1'b0, 4'h0, 1'b1);
      tick(1);
      checkOutput("dual_ack_pending", 32'(pending), 32'b0001);
      checkOutput("dual_ack_count", 32'(irq_count), 32'h2);
      applyStimulus(4'b1001, 4'hF, 1'b0, 4'h0, 1'b0);
`ifdef UART_IRQ_HOLDOFF_EN
      waitIrq(40);
`else
      tick(1);
`endif
      checkOutput("dual_second_irq", 32'(irq), 32'h1);
      checkOutput("dual_second_id", 32'(irq_id), 32'h0);
      applyStimulus(4'b1001, 4'hF, 1'b0, 4'h0, 1'b1);
      tick(1);
      checkOutput("dual_done_pending", 32'(pending), 32'h0);
      checkOutput("dual_done_count", 32'(irq_count), 32'h3);
      applyStimulus(4'h0, 4'hF, 1'b0, 4'h0, 1'b0);
      tick(1);

      // ack with nothing being signalled is ignored
      applyStimulus(4'h0, 4'hF, 1'b0, 4'h0, 1'b1);
      tick(2);
      checkOutput("idle_ack_count", 32'(irq_count), 32'h3);
      checkOutput("idle_ack_irq", 32'(irq), 32'h0);

      // set and clear on the same bit: set wins; then mask drops while active
      applyStimulus(4'b0010, 4'hF, 1'b1, 4'b0010, 1'b0);
      tick(1);
      checkOutput("set_wins_pending", 32'(pending), 32'b0010);
      applyStimulus(4'b0010, 4'hF, 1'b0, 4'h0, 1'b0);
      waitIrq(40);
      checkOutput("mask_irq_up", 32'(irq), 32'h1);
      checkOutput("mask_irq_id", 32'(irq_id), 32'h1);
      applyStimulus(4'b0010, 4'b1101, 1'b0, 4'h0, 1'b0);
      tick(1);
      checkOutput("mask_drop_irq", 32'(irq), 32'h0);
      checkOutput("mask_drop_count", 32'(irq_count), 32'h3);
      tick(1);
      checkOutput("mask_stay_idle", 32'(irq), 32'h0);
      applyStimulus(4'b0010, 4'b1101, 1'b1, 4'b0010, 1'b0);
      tick(1);
      checkOutput("w1c_pending", 32'(pending), 32'h0);
      applyStimulus(4'h0, 4'hF, 1'b0, 4'h0, 1'b0);
      tick(1);
      checkOutput("w1c_irq", 32'(irq), 32'h0);

      // tx_empty outranks rx_empty; reset mid-ACTIVE with status held
      applyStimulus(4'b0101, 4'hF, 1'b0, 4'h0, 1'b0);
      tick(1);
      checkOutput("prio_pending", 32'(pending), 32'b0101);
      waitIrq(40);
      checkOutput("prio_irq", 32'(irq), 32'h1);
      checkOutput("prio_id", 32'(irq_id), 32'h2);
      rst = 1'b1;
      tick(1);
      checkOutput("midrst_pending", 32'(pending), 32'h0);
      checkOutput("midrst_irq", 32'(irq), 32'h0);
      checkOutput("midrst_irq_id", 32'(irq_id), 32'h0);
      checkOutput("midrst_count", 32'(irq_count), 32'h0);
      rst = 1'b0;
      tick(1);
      checkOutput("postrst_pending", 32'(pending), 32'b0101);
      checkOutput("postrst_irq", 32'(irq), 32'h0);
      tick(1);
      checkOutput("postrst_irq_up", 32'(irq), 32'h1);
      checkOutput("postrst_id", 32'(irq_id), 32'h2);
      applyStimulus(4'b0101, 4'hF, 1'b0, 4'h0, 1'b1);
      tick(1);
      checkOutput("postrst_ack_pending", 32'(pending), 32'b0001);
      checkOutput("postrst_ack_count", 32'(irq_count), 32'h1);
      applyStimulus(4'b0101, 4'hF, 1'b0, 4'h0, 1'b0);
      waitIrq(40);
      checkOutput("postrst_second_id", 32'(irq_id), 32'h0);
      applyStimulus(4'b0101, 4'hF, 1'b0, 4'h0, 1'b1);
      tick(1);
      checkOutput("postrst_done_count", 32'(irq_count), 32'h2);
      applyStimulus(4'h0, 4'hF, 1'b0, 4'h0, 1'b0);
      tick(1);

`ifdef UART_IRQ_HOLDOFF_EN
      // holdoff: irq stays low 16 cycles after ack even with tx_empty pending
      applyStimulus(4'b0010, 4'hF, 1'b0, 4'h0, 1'b0);
      tick(1);
      waitIrq(40);
      checkOutput("hold_irq_up", 32'(irq), 32'h1);
      applyStimulus(4'b0010, 4'hF, 1'b0, 4'h0, 1'b1);
      tick(1);
      checkOutput("hold_irq_low_0", 32'(irq), 32'h0);
      for (int i = 1; i < 16; i++) begin
         applyStimulus((i == 1) ? 4'b0110 : status, 4'hF, 1'b0, 4'h0, 1'b0);
         tick(1);
         checkOutput($sformatf("hold_irq_low_%0d", i), 32'(irq), 32'h0);
      end
      waitIrq(4);
      checkOutput("hold_irq_back", 32'(irq), 32'h1);
      checkOutput("hold_irq_id", 32'(irq_id), 32'h2);
      applyStimulus(4'h0, 4'hF, 1'b0, 4'h0, 1'b1);
      tick(1);
      applyStimulus(4'h0, 4'hF, 1'b0, 4'h0, 1'b0);
      tick(1);
`endif

      // saturation of the ack counter
      for (int i = 0; i < 300; i++) begin
         applyStimulus(4'b0010, 4'hF, 1'b0, 4'h0, 1'b0);
         tick(1);
         applyStimulus(4'h0, 4'hF, 1'b0, 4'h0, 1'b0);
         waitIrq(40);
         checkOutput("sat_irq", 32'(irq), 32'h1);
         applyStimulus(4'h0, 4'hF, 1'b0, 4'h0, 1'b1);
         tick(1);
         applyStimulus(4'h0, 4'hF, 1'b0, 4'h0, 1'b0);
      end
      checkOutput("sat_count", 32'(irq_count), 32'hFF);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
